// File: rtl/hostsystem_dualport_memory_if.sv
// Avalon-MM slave port bundle for one side of the dual-port memory.
// Latency: none, this is wiring only.
// Backpressure: none; there is no waitrequest, so commands are always accepted.
interface hostsystem_dualport_memory_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0]   address;
   logic                    chipselect;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/hostsystem_dualport_memory.sv
// True-dual-port byte-enabled RAM with two Avalon-MM slaves, collision merge and cross-port forwarding.
// Latency: read data and readdatavalid appear 1 + OUT_REG enabled cycles after the read is presented.
// Backpressure: none; clken low freezes the whole block (memory and pipeline hold).
module hostsystem_dualport_memory #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024,
   parameter int OUT_REG    = 0,
   parameter     INIT_FILE  = "HostSystem_memory.hex"
) (
   input logic                        clk,
   input logic                        reset,
   input logic                        clken,
   hostsystem_dualport_memory_if.slave s1,
   hostsystem_dualport_memory_if.slave s2
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   // Power-up contents come from the device configuration image.
   (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Both ports gathered into arrays so the per-port logic is written once.
   logic [1:0][ADDR_WIDTH-1:0] addr;
   logic [1:0][NB-1:0]         be;
   logic [1:0][DATA_WIDTH-1:0] wdat;
   logic [1:0]                 cs;
   logic [1:0]                 rreq;
   logic [1:0]                 wreq;

   assign addr[0] = s1.address;
   assign addr[1] = s2.address;
   assign be[0]   = s1.byteenable;
   assign be[1]   = s2.byteenable;
   assign wdat[0] = s1.writedata;
   assign wdat[1] = s2.writedata;
   assign cs[0]   = s1.chipselect;
   assign cs[1]   = s2.chipselect;
   assign rreq[0] = s1.read;
   assign rreq[1] = s2.read;
   assign wreq[0] = s1.write;
   assign wreq[1] = s2.write;

   logic [1:0]                 rd_go;
   logic [1:0]                 in_rng;
   logic [1:0][IW-1:0]         idx;
   logic [1:0][NB-1:0]         lane_we;
   logic [1:0][DATA_WIDTH-1:0] rd_word;

   // Decode commands, resolve same-address write collisions and build forwarded read words.
   always_comb begin
      rd_go   = '0;
      in_rng  = '0;
      idx     = '0;
      lane_we = '0;
      rd_word = '0;
      for (int p = 0; p < 2; p++) begin
         // A write on the same port wins; the read is silently dropped.
         rd_go[p]   = cs[p] & clken & rreq[p] & ~wreq[p];
         in_rng[p]  = {1'b0, addr[p]} < DEPTH_W;
         idx[p]     = addr[p][IW-1:0];
         lane_we[p] = (cs[p] & clken & wreq[p] & in_rng[p]) ? be[p] : '0;
      end
      // s1 owns every lane it writes; s2 only fills the lanes s1 leaves alone.
      if (addr[1] == addr[0]) begin
         lane_we[1] = lane_we[1] & ~lane_we[0];
      end
      for (int p = 0; p < 2; p++) begin
         rd_word[p] = in_rng[p] ? mem[idx[p]] : '0;
         // After collision resolution at most one port owns a lane at a given address.
         for (int q = 0; q < 2; q++) begin
            for (int b = 0; b < NB; b++) begin
               if (lane_we[q][b] && (addr[q] == addr[p])) begin
                  rd_word[p][b*8 +: 8] = wdat[q][b*8 +: 8];
               end
            end
         end
      end
   end

   // Byte-lane writes from both ports; masks are already disjoint on a shared address.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < NB; b++) begin
            if (lane_we[p][b]) begin
               mem[idx[p]][b*8 +: 8] <= wdat[p][b*8 +: 8];
            end
         end
      end
   end

   logic [1:0]                 v1;
   logic [1:0][DATA_WIDTH-1:0] d1;
   logic [1:0]                 q_vld;
   logic [1:0][DATA_WIDTH-1:0] q_dat;

   // Stage 1: capture the read word; data only changes on a real read so it holds otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= '0;
         d1 <= '0;
      end else if (clken) begin
         v1 <= rd_go;
         for (int p = 0; p < 2; p++) begin
            if (rd_go[p]) begin
               d1[p] <= rd_word[p];
            end
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [1:0]                 v2;
         logic [1:0][DATA_WIDTH-1:0] d2;

         // Stage 2: optional output register, same hold rules as stage 1.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v2 <= '0;
               d2 <= '0;
            end else if (clken) begin
               v2 <= v1;
               for (int p = 0; p < 2; p++) begin
                  if (v1[p]) begin
                     d2[p] <= d1[p];
                  end
               end
            end
         end

         assign q_vld = v2;
         assign q_dat = d2;
      end else begin : g_noreg
         assign q_vld = v1;
         assign q_dat = d1;
      end
   endgenerate

   assign s1.readdatavalid = q_vld[0];
   assign s1.readdata      = q_dat[0];
   assign s2.readdatavalid = q_vld[1];
   assign s2.readdata      = q_dat[1];

endmodule
